// File: rtl/iq_envelope_detector.sv
// IQ envelope detector: computes round/floor(sqrt(I^2+Q^2)) for one sample per transaction,
// using a restoring digit-by-digit square root that produces one result bit per clock.
module iq_envelope_detector #(
    parameter int IQ_WIDTH  = 8,
    parameter int SIGNED    = 1,
    parameter int ROUND     = 1,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IQ_WIDTH-1:0]  i_in,
    input  logic [IQ_WIDTH-1:0]  q_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_mag,
    output logic                 out_exact
);

    // state  | meaning
    // IDLE   | waiting for an input sample (in_ready high)
    // SQUARE | forming the radicand I^2+Q^2
    // ROOT   | RW root iterations, then one cycle to round and register the result
    // DONE   | result presented, waiting for out_ready

    localparam int SUM_W = 2 * IQ_WIDTH + 2;
    localparam int RW    = IQ_WIDTH + 1;
    localparam int RW1   = RW + 1;
    localparam int CW    = RW + 3;
    localparam int CNT_W = $clog2(RW + 1);

    generate
        if (OUT_WIDTH < RW) begin : g_width_check
            $error("iq_envelope_detector: OUT_WIDTH must be at least IQ_WIDTH+1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} state_t;

    state_t              state;
    logic [IQ_WIDTH-1:0] i_reg;
    logic [IQ_WIDTH-1:0] q_reg;
    logic [SUM_W-1:0]    rad;
    logic [RW-1:0]       root;
    logic [RW:0]         rem;
    logic [CNT_W-1:0]    cnt;

    logic [SUM_W-1:0]    i_ext;
    logic [SUM_W-1:0]    q_ext;
    logic [SUM_W-1:0]    rad_next;
    logic [CW-1:0]       shifted;
    logic [CW-1:0]       trial;
    logic                take;
    logic [RW:0]         rem_next;
    logic                round_up;
    logic [RW-1:0]       mag_final;

    always_comb begin
        i_ext    = {{(SUM_W - IQ_WIDTH){(SIGNED != 0) && i_reg[IQ_WIDTH-1]}}, i_reg};
        q_ext    = {{(SUM_W - IQ_WIDTH){(SIGNED != 0) && q_reg[IQ_WIDTH-1]}}, q_reg};
        rad_next = i_ext * i_ext + q_ext * q_ext;
    end

    // One restoring step: bring down the next two radicand bits, try subtracting 4*root+1.
    always_comb begin
        shifted   = {rem, rad[SUM_W-1 -: 2]};
        trial     = {1'b0, root, 2'b01};
        take      = (shifted >= trial);
        rem_next  = take ? RW1'(shifted - trial) : RW1'(shifted);
        round_up  = (ROUND != 0) && (rem > {1'b0, root});
        mag_final = round_up ? root + RW'(1) : root;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_mag   <= '0;
            out_exact <= 1'b0;
            i_reg     <= '0;
            q_reg     <= '0;
            rad       <= '0;
            root      <= '0;
            rem       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        i_reg    <= i_in;
                        q_reg    <= q_in;
                        in_ready <= 1'b0;
                        state    <= SQUARE;
                    end
                end
                SQUARE: begin
                    rad   <= rad_next;
                    root  <= '0;
                    rem   <= '0;
                    cnt   <= '0;
                    state <= ROOT;
                end
                ROOT: begin
                    if (cnt == CNT_W'(RW)) begin
                        out_mag   <= OUT_WIDTH'(mag_final);
                        out_exact <= (rem == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        rem  <= rem_next;
                        root <= {root[RW-2:0], take};
                        rad  <= {rad[SUM_W-3:0], 2'b00};
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_envelope_detector.sv
// Bench for iq_envelope_detector: four parameter variants driven in lockstep and checked
// against an arithmetic integer-sqrt reference.
module tb_iq_envelope_detector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] i_in;
    logic [7:0] q_in;
    logic [3:0] rdy;
    logic [3:0] ov;
    logic [3:0] ex;
    logic [15:0] mag [4];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // index 0: signed/round, 1: signed/floor, 2: unsigned/round, 3: unsigned/floor
    for (genvar g = 0; g < 4; g++) begin : g_dut
        iq_envelope_detector #(
            .IQ_WIDTH (8),
            .SIGNED   ((g < 2) ? 1 : 0),
            .ROUND    ((g % 2 == 0) ? 1 : 0),
            .OUT_WIDTH(16)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (rdy[g]),
            .i_in     (i_in),
            .q_in     (q_in),
            .out_valid(ov[g]),
            .out_ready(out_ready),
            .out_mag  (mag[g]),
            .out_exact(ex[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int iv, input int qv, input int sgn, input int rnd,
                                  output int m, output int e);
        longint a = iv;
        longint b = qv;
        longint rad, r, rem;
        if (sgn != 0) begin
            if (a >= 128) a -= 256;
            if (b >= 128) b -= 256;
        end
        rad = a * a + b * b;
        r = 0;
        while ((r + 1) * (r + 1) <= rad) r++;
        rem = rad - r * r;
        m = int'((rnd != 0 && rem > r) ? r + 1 : r);
        e = (rem == 0) ? 1 : 0;
    endfunction

    task automatic run_sample(input int iv, input int qv);
        int k;
        int m, e;
        k = 0;
        while (rdy != 4'hF && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("ready_before_sample", rdy, 4'hF);
        @(negedge clk);
        in_valid = 1'b1;
        i_in = 8'(iv);
        q_in = 8'(qv);
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        while (ov == 4'h0 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("latency", k, 11);
        check("valid_all", ov, 4'hF);
        for (int g = 0; g < 4; g++) begin
            model(iv, qv, (g < 2) ? 1 : 0, (g % 2 == 0) ? 1 : 0, m, e);
            check($sformatf("mag%0d_%0d_%0d", g, iv, qv), mag[g], m);
            check($sformatf("exact%0d_%0d_%0d", g, iv, qv), ex[g], e);
        end
        if (out_ready) begin
            @(posedge clk); #1;
            check("valid_drop", ov, 4'h0);
            check("ready_after_hs", rdy, 4'hF);
        end
    endtask

    initial begin
        logic [15:0] held [4];
        rst_n = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        i_in = 8'd3;
        q_in = 8'd4;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", rdy, 4'h0);
        check("rst_out_valid", ov, 4'h0);
        check("rst_out_mag", mag[0], 0);
        check("rst_out_exact", ex, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_first_edge", rdy, 4'hF);
        in_valid = 1'b0;
        check("no_accept_in_reset", ov, 4'h0);

        run_sample(3, 4);
        run_sample(128, 128);
        run_sample(2, 3);
        run_sample(255, 255);
        run_sample(1, 1);
        run_sample(0, 0);
        run_sample(127, 0);
        run_sample(0, 129);

        // Backpressure: result held, ready low, new offers ignored
        out_ready = 1'b0;
        run_sample(5, 12);
        for (int g = 0; g < 4; g++) held[g] = mag[g];
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            i_in = 8'($urandom_range(0, 255));
            q_in = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            check("bp_mag0", mag[0], held[0]);
            check("bp_mag3", mag[3], held[3]);
            check("bp_ready", rdy, 4'h0);
            check("bp_valid", ov, 4'hF);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_hs_valid", ov, 4'h0);
        check("bp_hs_ready", rdy, 4'hF);

        // Reset during the root iterations aborts the computation
        @(negedge clk);
        in_valid = 1'b1;
        i_in = 8'd100;
        q_in = 8'd50;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_valid_in_rst", ov, 4'h0);
        check("abort_ready_in_rst", rdy, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            check("abort_no_result", ov, 4'h0);
        end
        check("abort_idle", rdy, 4'hF);
        run_sample(6, 8);

        for (int n = 0; n < 20; n++)
            run_sample(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
